seq_booth_mult: RTL and testbench



---
 rtl/seq_booth_mult_pkg.sv | 28 ++
 rtl/seq_booth_mult_booth_step.sv | 39 +++
 rtl/seq_booth_mult.sv | 132 +++++++++++++
 tb/tb_seq_booth_mult.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/seq_booth_mult_pkg.sv
// Shared types for the sequential Booth multiplier: FSM states, Booth
// operation codes and the radix-2 recoding helper.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    B_NOP = 2'd0,
    B_ADD = 2'd1,
    B_SUB = 2'd2
  } booth_op_t;

  // Radix-2 Booth recoding of the pair {Q[0], Q_1}.
  function automatic booth_op_t booth_decode(input logic q0, input logic q_1);
    booth_op_t op;
    case ({q0, q_1})
      2'b01:   op = B_ADD;
      2'b10:   op = B_SUB;
      default: op = B_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/seq_booth_mult_booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M into A,
// followed by an arithmetic right shift across {A, Q, Q_1}.
module booth_step
  import seq_mult_pkg::*;
#(
  parameter int W1 = 17
) (
  input  logic [W1-1:0] a_in,
  input  logic [W1-1:0] q_in,
  input  logic          q_1_in,
  input  logic [W1-1:0] m_in,
  output logic [W1-1:0] a_out,
  output logic [W1-1:0] q_out,
  output logic          q_1_out
);

  logic [W1-1:0] sum;
  booth_op_t     op;

  assign op = booth_decode(q_in[0], q_1_in);

  // Add/subtract at W1 bits; any carry out of the top bit is dropped.
  always_comb begin
    sum = a_in;
    case (op)
      B_ADD:   sum = a_in + m_in;
      B_SUB:   sum = a_in - m_in;
      default: sum = a_in;
    endcase
  end

  // Arithmetic shift right by one across the {A, Q, Q_1} chain.
  always_comb begin
    a_out   = {sum[W1-1], sum[W1-1:1]};
    q_out   = {sum[0], q_in[W1-1:1]};
    q_1_out = q_in[0];
  end

endmodule

// File: rtl/seq_booth_mult.sv
// Sequential radix-2 Booth multiplier with valid/ready on both sides.
// Operands are widened by one bit (sign or zero extension, chosen per
// transaction) so the same signed Booth datapath serves both modes.
//
// state | meaning
// IDLE  | src_ready high, waiting for an operand pair
// CALC  | one Booth step per cycle, W1 steps in total
// DONE  | dest_valid high, product held until dest_ready
module seq_booth_mult
  import seq_mult_pkg::*;
#(
  parameter  int WIDTH  = 16,
  localparam int PWIDTH = 2 * WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              src_valid,
  output logic              src_ready,
  input  logic [WIDTH-1:0]  multiplicand,
  input  logic [WIDTH-1:0]  multiplier,
  input  logic              signed_mode,
  output logic              dest_valid,
  input  logic              dest_ready,
  output logic [PWIDTH-1:0] product,
  output logic              busy
);

  localparam int W1 = WIDTH + 1;
  localparam int CW = $clog2(W1 + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(W1 - 1);

  state_t            state_q,   state_d;
  logic [W1-1:0]     m_q,       m_d;
  logic [W1-1:0]     a_q,       a_d;
  logic [W1-1:0]     q_q,       q_d;
  logic              q1_q,      q1_d;
  logic [CW-1:0]     count_q,   count_d;
  logic [PWIDTH-1:0] product_q, product_d;

  logic [W1-1:0]     step_a;
  logic [W1-1:0]     step_q;
  logic              step_q1;
  logic [W1-1:0]     m_ext;
  logic [W1-1:0]     q_ext;

  assign m_ext = {signed_mode & multiplicand[WIDTH-1], multiplicand};
  assign q_ext = {signed_mode & multiplier[WIDTH-1], multiplier};

  booth_step #(
    .W1 (W1)
  ) u_booth_step (
    .a_in    (a_q),
    .q_in    (q_q),
    .q_1_in  (q1_q),
    .m_in    (m_q),
    .a_out   (step_a),
    .q_out   (step_q),
    .q_1_out (step_q1)
  );

  // Next-state, datapath loads and counter; clear overrides everything.
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    a_d       = a_q;
    q_d       = q_q;
    q1_d      = q1_q;
    count_d   = count_q;
    product_d = product_q;
    if (clear) begin
      state_d   = IDLE;
      count_d   = '0;
      product_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (src_valid) begin
            m_d     = m_ext;
            q_d     = q_ext;
            a_d     = '0;
            q1_d    = 1'b0;
            count_d = '0;
            state_d = CALC;
          end
        end
        CALC: begin
          a_d     = step_a;
          q_d     = step_q;
          q1_d    = step_q1;
          count_d = count_q + CW'(1);
          // Final step: capture the product from the step result directly.
          if (count_q == CNT_LAST) begin
            product_d = PWIDTH'({step_a, step_q});
            state_d   = DONE;
          end
        end
        DONE: begin
          if (dest_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      m_q       <= '0;
      a_q       <= '0;
      q_q       <= '0;
      q1_q      <= 1'b0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      a_q       <= a_d;
      q_q       <= q_d;
      q1_q      <= q1_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  assign src_ready  = (state_q == IDLE);
  assign dest_valid = (state_q == DONE);
  assign busy       = (state_q == CALC) || (state_q == DONE);
  assign product    = product_q;

endmodule

// File: tb/tb_seq_booth_mult.sv
// Directed bench for seq_booth_mult at WIDTH=16 and WIDTH=8.
module tb_seq_booth_mult;

  logic clk;
  logic rst_n;

  logic        clear16, src_valid16, src_ready16, sm16, dest_valid16, dest_ready16, busy16;
  logic [15:0] mc16, mp16;
  logic [31:0] prod16;

  logic        clear8, src_valid8, src_ready8, sm8, dest_valid8, dest_ready8, busy8;
  logic [7:0]  mc8, mp8;
  logic [15:0] prod8;

  int passed = 0;
  int total  = 0;

  seq_booth_mult #(.WIDTH(16)) u_dut16 (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear16),
    .src_valid    (src_valid16),
    .src_ready    (src_ready16),
    .multiplicand (mc16),
    .multiplier   (mp16),
    .signed_mode  (sm16),
    .dest_valid   (dest_valid16),
    .dest_ready   (dest_ready16),
    .product      (prod16),
    .busy         (busy16)
  );

  seq_booth_mult #(.WIDTH(8)) u_dut8 (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear8),
    .src_valid    (src_valid8),
    .src_ready    (src_ready8),
    .multiplicand (mc8),
    .multiplier   (mp8),
    .signed_mode  (sm8),
    .dest_valid   (dest_valid8),
    .dest_ready   (dest_ready8),
    .product      (prod8),
    .busy         (busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Present one operand pair for a single cycle; returns just after E0.
  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic s);
    mc16 = a; mp16 = b; sm16 = s; src_valid16 = 1'b1;
    @(posedge clk); #1;
    src_valid16 = 1'b0;
  endtask

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic s);
    mc8 = a; mp8 = b; sm8 = s; src_valid8 = 1'b1;
    @(posedge clk); #1;
    src_valid8 = 1'b0;
  endtask

  // Count cycles from E0 until dest_valid, bounded.
  task automatic wait_done16(input string tag, input int exp_lat);
    int cyc = 0;
    while (!dest_valid16 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
  endtask

  task automatic wait_done8(input string tag, input int exp_lat);
    int cyc = 0;
    while (!dest_valid8 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
  endtask

  task automatic take16;
    dest_ready16 = 1'b1;
    @(posedge clk); #1;
    dest_ready16 = 1'b0;
  endtask

  task automatic take8;
    dest_ready8 = 1'b1;
    @(posedge clk); #1;
    dest_ready8 = 1'b0;
  endtask

  task automatic mult16(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic [31:0] exp);
    send16(a, b, s);
    wait_done16(tag, 17);
    check(tag, 64'(prod16), 64'(exp));
    take16();
    check({tag, "_ready_after"}, 64'(src_ready16), 64'd1);
  endtask

  task automatic mult8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic s, input logic [15:0] exp);
    send8(a, b, s);
    wait_done8(tag, 9);
    check(tag, 64'(prod8), 64'(exp));
    take8();
  endtask

  initial begin
    rst_n = 1'b1;
    clear16 = 0; src_valid16 = 0; sm16 = 0; dest_ready16 = 0; mc16 = '0; mp16 = '0;
    clear8  = 0; src_valid8  = 0; sm8  = 0; dest_ready8  = 0; mc8  = '0; mp8  = '0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_src_ready",  64'(src_ready16),  64'd1);
    check("rst_dest_valid", 64'(dest_valid16), 64'd0);
    check("rst_busy",       64'(busy16),       64'd0);
    check("rst_product",    64'(prod16),       64'd0);
    check("rst_product8",   64'(prod8),        64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic products at WIDTH=16.
    mult16("s_m3x5",       16'hFFFD, 16'h0005, 1'b1, 32'hFFFF_FFF1);
    mult16("u_ffffxffff",  16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001);
    mult16("s_m1xm1",      16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001);
    mult16("s_minxmin",    16'h8000, 16'h8000, 1'b1, 32'h4000_0000);
    mult16("s_minxmax",    16'h8000, 16'h7FFF, 1'b1, 32'hC000_8000);

    // WIDTH=8 instance.
    mult8("u8_200x100",  8'd200, 8'd100, 1'b0, 16'h4E20);
    mult8("s8_m128x127", 8'h80,  8'h7F,  1'b1, 16'hC080);

    // Backpressure: hold the result while new operands sit on the input.
    send16(16'd3, 16'd4, 1'b1);
    wait_done16("bp", 17);
    mc16 = 16'd7; mp16 = 16'd6; sm16 = 1'b1; src_valid16 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold_product", 64'(prod16),       64'd12);
      check("bp_hold_valid",   64'(dest_valid16), 64'd1);
      check("bp_src_ready",    64'(src_ready16),  64'd0);
    end
    dest_ready16 = 1'b1;
    @(posedge clk); #1;
    dest_ready16 = 1'b0;
    check("bp_release_ready", 64'(src_ready16),  64'd1);
    check("bp_release_valid", 64'(dest_valid16), 64'd0);
    @(posedge clk); #1;
    src_valid16 = 1'b0;
    check("bp_next_accepted", 64'(busy16), 64'd1);
    wait_done16("bp_next", 17);
    check("bp_next_product", 64'(prod16), 64'd42);
    take16();

    // clear in IDLE with src_valid high must not accept.
    mc16 = 16'd9; mp16 = 16'd9; sm16 = 1'b0; src_valid16 = 1'b1; clear16 = 1'b1;
    @(posedge clk); #1;
    src_valid16 = 1'b0; clear16 = 1'b0;
    check("clr_idle_busy", 64'(busy16), 64'd0);

    // Abort with clear during step 7; product (still 42) must be wiped.
    send16(16'd100, 16'd100, 1'b0);
    repeat (6) begin @(posedge clk); #1; end
    clear16 = 1'b1;
    @(posedge clk); #1;
    clear16 = 1'b0;
    check("clr_src_ready",  64'(src_ready16),  64'd1);
    check("clr_dest_valid", 64'(dest_valid16), 64'd0);
    check("clr_busy",       64'(busy16),       64'd0);
    check("clr_product",    64'(prod16),       64'd0);
    mult16("clr_6x7", 16'd6, 16'd7, 1'b1, 32'd42);

    // Abort with an asynchronous reset pulse mid-CALC.
    send16(16'd100, 16'd100, 1'b0);
    repeat (6) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    check("arst_src_ready", 64'(src_ready16), 64'd1);
    check("arst_busy",      64'(busy16),      64'd0);
    check("arst_product",   64'(prod16),      64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mult16("arst_6x7", 16'd6, 16'd7, 1'b1, 32'd42);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
